// File: rtl/uart_rcv_frame_ctrl_pkg.sv
// rtl/uart_rcv_frame_ctrl_pkg.sv - shared state encoding and constants for the UART receive frame controller
package uart_rcv_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } rcv_state_e;

    localparam int DEFAULT_DATA_BITS = 8;

    // Clocks per bit period seen by the receiver (BaudClock = Clock/16)
    localparam int BAUD_DIV = 16;

endpackage

// File: rtl/uart_rcv_frame_ctrl_if.sv
// rtl/uart_rcv_frame_ctrl_if.sv - CPU-side read interface of the UART receive frame controller
interface uart_rcv_frame_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic                 ReadStrobe;
    logic [DATA_BITS-1:0] RxData;
    logic                 RxReady;
    logic                 FramingError;
    logic                 OverrunError;
    logic                 ParityError;

    // CPU / bus side
    modport master (
        output ReadStrobe,
        input  RxData,
        input  RxReady,
        input  FramingError,
        input  OverrunError,
        input  ParityError
    );

    // Receiver side
    modport slave (
        input  ReadStrobe,
        output RxData,
        output RxReady,
        output FramingError,
        output OverrunError,
        output ParityError
    );
endinterface

// File: rtl/uart_rcv_frame_ctrl_baud_tick.sv
// rtl/uart_rcv_frame_ctrl_baud_tick.sv - rising-edge detector turning BaudClock into a one-Clock BaudTick
module rcv_baud_tick (
    input  logic Clock,
    input  logic Reset,
    input  logic i_baud_clock,
    output logic o_baud_tick
);
    logic r_baud_clock_d;

    // Delay BaudClock by one Clock so its rising edge can be isolated
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_baud_clock_d <= 1'b0;
        end else begin
            r_baud_clock_d <= i_baud_clock;
        end
    end

    assign o_baud_tick = i_baud_clock & ~r_baud_clock_d;

endmodule

// File: rtl/uart_rcv_frame_ctrl.sv
// rtl/uart_rcv_frame_ctrl.sv - UART receive frame FSM, word assembly and CPU flags; parity via UART_RCV_PARITY_EN
module uart_rcv_frame_ctrl
    import uart_rcv_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int ODD_PARITY = 0
) (
    input  logic Clock,
    input  logic Reset,
    input  logic RxD,
    input  logic StartDetect,
    input  logic BaudClock,
    output logic Idle,
    output logic Shift,
    uart_rcv_frame_ctrl_if.slave cpu
);
    localparam int                 CNT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(DATA_BITS - 1);

    rcv_state_e           r_state;
    rcv_state_e           w_next;
    logic                 w_tick;
    logic                 w_commit;
    logic                 w_rd_clear;
    logic [DATA_BITS-1:0] r_shift;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_ready;
    logic                 r_framing_err;
    logic                 r_overrun_err;

    rcv_baud_tick u_baud_tick (
        .Clock        (Clock),
        .Reset        (Reset),
        .i_baud_clock (BaudClock),
        .o_baud_tick  (w_tick)
    );

    // State register; reset drops any partial frame
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus Idle/Shift handshakes back to the start detector
    always_comb begin
        w_next   = r_state;
        Idle     = 1'b0;
        Shift    = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            S_IDLE: begin
                Idle = 1'b1;
                if (StartDetect) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_next = RxD ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                Shift = 1'b1;
                if (w_tick && (r_bit_cnt == LAST_BIT)) begin
`ifdef UART_RCV_PARITY_EN
                    w_next = S_PARITY;
`else
                    w_next = S_STOP;
`endif
                end
            end
`ifdef UART_RCV_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    w_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    w_commit = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // LSB-first word assembly: each mid-bit sample enters at the MSB
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else begin
            if ((r_state == S_START) && w_tick && !RxD) begin
                r_bit_cnt <= '0;
            end
            if ((r_state == S_DATA) && w_tick) begin
                r_shift   <= {RxD, r_shift[DATA_BITS-1:1]};
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
        end
    end

    // A read only clears flags when there is actually a word to read
    assign w_rd_clear = cpu.ReadStrobe & r_rx_ready;

`ifdef UART_RCV_PARITY_EN
    localparam logic ODD_BIT = (ODD_PARITY != 0);

    logic r_par_bit;
    logic r_parity_err;
    logic w_par_bad;

    // Capture the received parity bit at its mid-bit tick
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_par_bit <= 1'b0;
        end else if ((r_state == S_PARITY) && w_tick) begin
            r_par_bit <= RxD;
        end
    end

    assign w_par_bad = r_par_bit ^ (^r_shift) ^ ODD_BIT;

    // Sticky parity flag, same commit/clear rules as the other error flags
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_parity_err <= 1'b0;
        end else if (w_commit) begin
            r_parity_err <= (r_parity_err & ~w_rd_clear) | w_par_bad;
        end else if (w_rd_clear) begin
            r_parity_err <= 1'b0;
        end
    end

    assign cpu.ParityError = r_parity_err;
`else
    assign cpu.ParityError = 1'b0;
`endif

    // Commit beats a coincident read: old flags drop, this frame's errors stay
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_rx_data     <= '0;
            r_rx_ready    <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else if (w_commit) begin
            r_rx_data     <= r_shift;
            r_rx_ready    <= 1'b1;
            r_framing_err <= (r_framing_err & ~w_rd_clear) | ~RxD;
            r_overrun_err <= (r_overrun_err & ~w_rd_clear) | (r_rx_ready & ~cpu.ReadStrobe);
        end else if (w_rd_clear) begin
            r_rx_ready    <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end
    end

    assign cpu.RxData       = r_rx_data;
    assign cpu.RxReady      = r_rx_ready;
    assign cpu.FramingError = r_framing_err;
    assign cpu.OverrunError = r_overrun_err;

endmodule

// File: tb/tb_uart_rcv_frame_ctrl.sv
// tb/tb_uart_rcv_frame_ctrl.sv - self-checking bench for uart_rcv_frame_ctrl
module tb_uart_rcv_frame_ctrl;
    import uart_rcv_pkg::*;

    localparam int DB  = 8;
    localparam int ODD = 0;

    logic Clock = 1'b0;
    logic Reset;
    logic RxD;
    logic StartDetect;
    logic BaudClock;
    logic Idle;
    logic Shift;

    uart_rcv_frame_ctrl_if #(.DATA_BITS(DB)) cpu ();

    uart_rcv_frame_ctrl #(.DATA_BITS(DB), .ODD_PARITY(ODD)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .RxD         (RxD),
        .StartDetect (StartDetect),
        .BaudClock   (BaudClock),
        .Idle        (Idle),
        .Shift       (Shift),
        .cpu         (cpu)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DB-1:0] exp_data  = '0;
    logic          exp_ready = 1'b0;
    logic          exp_fe    = 1'b0;
    logic          exp_oe    = 1'b0;
    logic          exp_pe    = 1'b0;

    logic       det      = 1'b0;
    logic       last_rxd = 1'b1;
    logic [3:0] bcnt     = 4'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison of CPU-visible outputs against the frame-level model
    always @(posedge Clock) begin
        #1;
        chk("rx_data",   32'(cpu.RxData),       32'(exp_data));
        chk("rx_ready",  32'(cpu.RxReady),      32'(exp_ready));
        chk("framing",   32'(cpu.FramingError), 32'(exp_fe));
        chk("overrun",   32'(cpu.OverrunError), 32'(exp_oe));
        chk("parity",    32'(cpu.ParityError),  32'(exp_pe));
    end

    // One Clock of stimulus, including a behavioural start detector / baud counter
    task automatic step(input logic rxd, input logic rd);
        @(negedge Clock);
        RxD            = rxd;
        cpu.ReadStrobe = rd;
        if (det && !Idle) det = 1'b0;
        if (!det && Idle && !last_rxd) begin
            det  = 1'b1;
            bcnt = 4'd0;
        end else begin
            bcnt = bcnt + 4'd1;
        end
        last_rxd    = rxd;
        StartDetect = det;
        BaudClock   = bcnt[3];
    endtask

    task automatic model_commit(input logic [DB-1:0] d, input logic stop, input logic bad, input logic rd);
        if (rd && exp_ready) begin
            exp_fe = 1'b0;
            exp_oe = 1'b0;
            exp_pe = 1'b0;
        end
        if (exp_ready && !rd) exp_oe = 1'b1;
        if (!stop) exp_fe = 1'b1;
        if (bad) exp_pe = 1'b1;
        exp_data  = d;
        exp_ready = 1'b1;
    endtask

    task automatic do_read();
        step(1'b1, 1'b1);
        if (exp_ready) begin
            exp_ready = 1'b0;
            exp_fe    = 1'b0;
            exp_oe    = 1'b0;
            exp_pe    = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic par_bad, input logic rd_at_commit);
        logic bits[$];
        logic bad_eff;
        logic commit;
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(d[i]);
`ifdef UART_RCV_PARITY_EN
        bits.push_back((^d) ^ (ODD != 0) ^ par_bad);
        bad_eff = par_bad;
`else
        bad_eff = 1'b0;
`endif
        bits.push_back(stop);
        for (int k = 0; k < bits.size(); k++) begin
            for (int c = 0; c < BAUD_DIV; c++) begin
                commit = (k == bits.size() - 1) && (c == 9);
                step(bits[k], commit && rd_at_commit);
                if (commit) model_commit(d, stop, bad_eff, rd_at_commit);
                if (k == 2 && c == 12) chk("shift_in_data", 32'(Shift), 32'd1);
            end
        end
    endtask

    initial begin
        Reset          = 1'b1;
        RxD            = 1'b1;
        StartDetect    = 1'b0;
        BaudClock      = 1'b0;
        cpu.ReadStrobe = 1'b0;
        repeat (3) @(negedge Clock);
        chk("rst_idle",  32'(Idle),        32'd1);
        chk("rst_shift", 32'(Shift),       32'd0);
        chk("rst_ready", 32'(cpu.RxReady), 32'd0);
        chk("rst_data",  32'(cpu.RxData),  32'd0);
        Reset = 1'b0;
        idle(20);

        // Clean frame 0xA3
        send_frame(8'hA3, 1'b1, 1'b0, 1'b0);
        idle(20);
        chk("a3_data",  32'(cpu.RxData),       32'hA3);
        chk("a3_ready", 32'(cpu.RxReady),      32'd1);
        chk("a3_fe",    32'(cpu.FramingError), 32'd0);
        chk("a3_idle",  32'(Idle),             32'd1);
        do_read();
        idle(2);
        chk("a3_read_ready", 32'(cpu.RxReady), 32'd0);

        // False start: low for 9 Clocks then back high before the start tick
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0);
        idle(40);
        chk("false_ready", 32'(cpu.RxReady),      32'd0);
        chk("false_fe",    32'(cpu.FramingError), 32'd0);
        chk("false_idle",  32'(Idle),             32'd1);

        // Framing error on 0x55; data still committed
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        idle(40);
        chk("fe_data",  32'(cpu.RxData),       32'h55);
        chk("fe_ready", 32'(cpu.RxReady),      32'd1);
        chk("fe_flag",  32'(cpu.FramingError), 32'd1);
        do_read();
        idle(2);
        chk("fe_clr_ready", 32'(cpu.RxReady),      32'd0);
        chk("fe_clr_flag",  32'(cpu.FramingError), 32'd0);

        // Overrun: two frames without a read
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        idle(20);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        idle(20);
        chk("ovr_data", 32'(cpu.RxData),       32'h22);
        chk("ovr_flag", 32'(cpu.OverrunError), 32'd1);
        do_read();
        idle(4);
        chk("ovr_clr", 32'(cpu.OverrunError), 32'd0);

        // Read coincident with the second commit: commit wins, no overrun
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        idle(20);
        send_frame(8'h22, 1'b1, 1'b0, 1'b1);
        idle(20);
        chk("coin_data",  32'(cpu.RxData),       32'h22);
        chk("coin_ready", 32'(cpu.RxReady),      32'd1);
        chk("coin_ovr",   32'(cpu.OverrunError), 32'd0);

        // Reset after the 4th data bit of 0xFF, with 0x22 still unread
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < BAUD_DIV; c++) step((k == 0) ? 1'b0 : 1'b1, 1'b0);
        end
        @(negedge Clock);
        Reset     = 1'b1;
        exp_data  = '0;
        exp_ready = 1'b0;
        exp_fe    = 1'b0;
        exp_oe    = 1'b0;
        exp_pe    = 1'b0;
        idle(3);
        chk("mid_rst_idle",  32'(Idle),        32'd1);
        chk("mid_rst_shift", 32'(Shift),       32'd0);
        chk("mid_rst_ready", 32'(cpu.RxReady), 32'd0);
        chk("mid_rst_data",  32'(cpu.RxData),  32'd0);
        Reset = 1'b0;
        idle(40);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        idle(20);
        chk("post_rst_data",  32'(cpu.RxData),       32'h3C);
        chk("post_rst_ready", 32'(cpu.RxReady),      32'd1);
        chk("post_rst_ovr",   32'(cpu.OverrunError), 32'd0);
        do_read();
        idle(4);

`ifdef UART_RCV_PARITY_EN
        // 0x07 has three ones: even parity bit must be 1
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        idle(20);
        chk("par_ok", 32'(cpu.ParityError), 32'd0);
        do_read();
        idle(4);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        idle(20);
        chk("par_bad",      32'(cpu.ParityError), 32'd1);
        chk("par_bad_data", 32'(cpu.RxData),      32'h07);
        do_read();
        idle(4);
        chk("par_clr", 32'(cpu.ParityError), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
